// File: rtl/write_cycle_pkg.sv
// Shared RTC bus header: write-FSM state encoding, default timing constants
// and the per-state bus output decode.
package write_cycle_pkg;

    typedef enum logic [2:0] {
        W0 = 3'd0,  // IDLE
        W1 = 3'd1,  // ADDR_SETUP
        W2 = 3'd2,  // ADDR_STROBE
        W3 = 3'd3,  // ADDR_HOLD
        W4 = 3'd4,  // DATA_SETUP
        W5 = 3'd5,  // DATA_STROBE
        W6 = 3'd6,  // DATA_HOLD
        W7 = 3'd7   // DONE
    } wstate_t;

    localparam int DEF_T_ADS = 2;
    localparam int DEF_T_CSW = 4;
    localparam int DEF_T_ADH = 2;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = 1 << CNT_W;

    typedef struct packed {
        logic [7:0] ad_out;
        logic       ad_oe;
        logic       ad;
        logic       cs;
        logic       wr;
        logic       busy;
        logic       write_end;
    } bus_t;

    // Bus levels for a state; the bus is released (ad_out=0) unless ad_oe.
    function automatic bus_t decode(input wstate_t st, input logic [7:0] a, input logic [7:0] d);
        bus_t b;
        b = '{ad_out: 8'h00, ad_oe: 1'b0, ad: 1'b1, cs: 1'b1, wr: 1'b1,
               busy: 1'b1, write_end: 1'b0};
        case (st)
            W1, W3: begin b.ad = 1'b0; b.ad_oe = 1'b1; b.ad_out = a; end
            W2: begin
                b.ad = 1'b0; b.cs = 1'b0; b.wr = 1'b0;
                b.ad_oe = 1'b1; b.ad_out = a;
            end
            W4, W6: begin b.ad_oe = 1'b1; b.ad_out = d; end
            W5: begin
                b.cs = 1'b0; b.wr = 1'b0;
                b.ad_oe = 1'b1; b.ad_out = d;
            end
            W7:      b.write_end = 1'b1;
            default: b.busy = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/write_cycle_timer.sv
// 8-bit loadable down-counter that parks at zero; times the setup/strobe/hold
// intervals of the write FSM.
module write_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != 8'd0)
            count <= count - 8'd1;
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/write_cycle.sv
// Bus-master FSM for one write on the multiplexed RTC AD bus: address phase
// then data phase, each with setup, strobe and hold intervals.
module write_cycle
    import write_cycle_pkg::*;
#(
    parameter int T_ADS = DEF_T_ADS,
    parameter int T_CSW = DEF_T_CSW,
    parameter int T_ADH = DEF_T_ADH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       busy,
    output logic       write_end,
    output logic [2:0] state
);

    if (T_ADS < 1 || T_ADS > CNT_MAX || T_CSW < 1 || T_CSW > CNT_MAX ||
        T_ADH < 1 || T_ADH > CNT_MAX) begin : g_bad_timing
        $error("write_cycle: T_ADS/T_CSW/T_ADH must lie in 1..256");
    end

    localparam logic [CNT_W-1:0] LD_ADS = CNT_W'(T_ADS - 1);
    localparam logic [CNT_W-1:0] LD_CSW = CNT_W'(T_CSW - 1);
    localparam logic [CNT_W-1:0] LD_ADH = CNT_W'(T_ADH - 1);

    wstate_t          state_q, state_nxt;
    logic [7:0]       addr_q, addr_nxt;
    logic [7:0]       wdata_q, wdata_nxt;
    bus_t             bus_q;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             zero;

    write_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        load_val  = '0;
        case (state_q)
            W0: if (start) begin
                state_nxt = W1;
                addr_nxt  = addr;
                wdata_nxt = wdata;
            end
            W1:      if (zero) state_nxt = W2;
            W2:      if (zero) state_nxt = W3;
            W3:      if (zero) state_nxt = W4;
            W4:      if (zero) state_nxt = W5;
            W5:      if (zero) state_nxt = W6;
            W6:      if (zero) state_nxt = W7;
            W7:      state_nxt = W0;
            default: state_nxt = W0;
        endcase

        // Timer reloads only when stepping into a timed state.
        load = (state_nxt != state_q) && (state_nxt != W0) && (state_nxt != W7);
        case (state_nxt)
            W1, W4:  load_val = LD_ADS;
            W2, W5:  load_val = LD_CSW;
            W3, W6:  load_val = LD_ADH;
            default: load_val = '0;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with
    // state_q and never see an input combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= W0;
            addr_q  <= '0;
            wdata_q <= '0;
            bus_q   <= decode(W0, 8'h00, 8'h00);
        end else begin
            state_q <= state_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            bus_q   <= decode(state_nxt, addr_nxt, wdata_nxt);
        end
    end

    assign ad_out    = bus_q.ad_out;
    assign ad_oe     = bus_q.ad_oe;
    assign AD        = bus_q.ad;
    assign CS        = bus_q.cs;
    assign WR        = bus_q.wr;
    assign RD        = 1'b1;
    assign busy      = bus_q.busy;
    assign write_end = bus_q.write_end;
    assign state     = state_q;

endmodule

// File: doc/write_cycle.md
# write_cycle

Bus-master FSM that performs one write transaction on the RTC's multiplexed address/data bus. It is the write-direction counterpart of the read-cycle controller and shares the same strobe conventions: AD low means address phase, and CS, RD and WR are active low. It sits between the top-level RTC controller, which issues start, address and data, and the external 8-bit AD bus tristate pad. It sequences the address phase, then the data phase, each with setup, strobe and hold intervals counted in clocks.

## Interface
- T_ADS, default 2: address/data setup time in clocks, ≥1.
- T_CSW, default 4: CS/WR strobe width in clocks, ≥1.
- T_ADH, default 2: address/data hold time in clocks, ≥1.
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a write; sampled only in IDLE.
- addr  in  8  target register address; captured when start is accepted.
- wdata  in  8  write data; captured when start is accepted.
- ad_out  out  8  value to drive on the AD bus.
- ad_oe  out  1  pad output enable; 1 = drive ad_out.
- AD  out  1  address/data select; 0 = address phase.
- CS  out  1  chip select, active low.
- RD  out  1  read strobe; constant 1.
- WR  out  1  write strobe, active low.
- busy  out  1  high in every state except IDLE.
- write_end  out  1  one-cycle pulse marking completion.
- state  out  3  current state, for debug.

## Operation
- Moore FSM with 3-bit registered state. All outputs decode from state and the captured registers only; no input reaches an output combinationally.
- In IDLE, start=1 captures addr and wdata into internal registers and moves to W1. While busy, start, addr and wdata are ignored.
- Strobe values per state are listed as AD/CS/WR; ad_oe and ad_out are given separately:
  - IDLE 000: AD/CS/WR = 1/1/1; ad_oe=0.
  - W1 001 ADDR_SETUP: 0/1/1; ad_oe=1, ad_out=addr_q. Lasts T_ADS cycles.
  - W2 010 ADDR_STROBE: 0/0/0; drives addr_q. Lasts T_CSW cycles.
  - W3 011 ADDR_HOLD: 0/1/1; drives addr_q. Lasts T_ADH cycles.
  - W4 100 DATA_SETUP: 1/1/1; ad_out=wdata_q. Lasts T_ADS cycles.
  - W5 101 DATA_STROBE: 1/0/0; drives wdata_q. Lasts T_CSW cycles.
  - W6 110 DATA_HOLD: 1/1/1; drives wdata_q. Lasts T_ADH cycles.
  - W7 111 DONE: 1/1/1; ad_oe=0, write_end=1. Lasts 1 cycle, then goes to IDLE unconditionally.
- Timing of the timed states (W1–W6):
  - On the transition into a timed state, the timer loads that state's count minus 1.
  - The state advances on the edge where the timer reads 0, so each timed state lasts exactly its parameter in cycles.
- RD is 1 in all states, including reset.
- ad_out is 0 whenever ad_oe=0.
- CS and WR always fall and rise together.
- AD changes only while CS=WR=1.
- Unused or illegal encodings cannot occur with 3 bits. The default branch still maps to IDLE outputs and next state IDLE.

## Timing
- Reset values:
  - state=IDLE.
  - AD=CS=RD=WR=1.
  - ad_oe=0, ad_out=0.
  - busy=0, write_end=0.
  - addr_q=wdata_q=0.
  - Timer cleared.
- Latency from start=1 in IDLE (cycle 0) to the write_end pulse: 1 + 2·(T_ADS+T_CSW+T_ADH) cycles. With defaults that is cycle 17. IDLE follows at cycle 18.
- Back-to-back: start held high in the IDLE cycle after DONE launches the next transaction. The minimum spacing is 2·(T_ADS+T_CSW+T_ADH)+2 cycles.
- Reset mid-transaction: at the next edge, state goes to IDLE, strobes go high and the bus is released in the same cycle. No write_end is produced.
- rst and start high together: rst wins.
- Counter width is 8 bits. Parameters above 256 are illegal and are checked by an elaboration-time assertion.

## Structure
- The shared RTC header holds:
  - the state encoding constants W0–W7, matching the read controller's numbering style;
  - the default timing constants T_ADS, T_CSW and T_ADH.
- One sub-module, write_timer: an 8-bit loadable down-counter.
  - Ports: clk, rst, load, load_val[7:0], zero.
  - zero is high when the count is 0.
  - It holds at 0 when not loaded.

## Test plan
- Reset, then idle for 5 cycles → outputs: AD=CS=RD=WR=1, ad_oe=0, busy=0, write_end=0.
- start=1 at cycle 0 with addr=0x0A, wdata=0x5C, default parameters → expected sequence:
  - cycles 1–8: ad_out=0x0A, AD=0; CS=WR=0 exactly in cycles 3–6.
  - cycles 9–16: ad_out=0x5C, AD=1; CS=WR=0 exactly in cycles 11–14.
  - cycle 17: write_end=1.
  - cycle 18: IDLE.
- Change addr to 0xFF and wdata to 0x00 and pulse start during cycle 5 of a transaction → bus still carries 0x0A, then 0x5C, and no second transaction starts.
- Assert rst in cycle 12 (during DATA_STROBE) → cycle 13: CS=WR=1, ad_oe=0, busy=0, with no write_end pulse.
- Hold start high continuously → write_end pulses at cycles 17 and 35, and each transaction shows the full 8-cycle address phase.
- Set T_ADS=T_CSW=T_ADH=1 → write_end appears at cycle 7, and each of states W1–W6 is observed for exactly one cycle.
